imem_fetch: RTL and testbench
=============================

Name: imem_fetch

Overview:
- Instruction-side responder for the 16-bit myMIPS core.
- Holds the program counter and the instruction memory.
- Answers the control unit's rom_rd request with a registered ROM_data word and an instr_valid qualifier.
- Applies PC_MUX redirects (sequential, beq, j, jr) and squashes the wrong-path fetch.
- A boot-time program-load port fills the memory before execution starts.

Parameters:
- ADDR_W, 8: instruction memory address width; depth = 2**ADDR_W words.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rom_rd  in  1  fetch request from control; 0 = stall/hold
- PC_MUX  in  2  next-PC select: 01 seq, 10 branch, 11 jump, 00 jr
- branch_taken  in  1  ALU equality result; qualifies PC_MUX=10
- branch_offset  in  6  signed word offset, instr[5:0]
- jump_addr  in  12  j target, instr[11:0]
- jr_target  in  16  register value for jr
- prog_we  in  1  program-load write strobe
- prog_addr  in  16  program-load word address
- prog_data  in  16  program-load data
- prog_done  in  1  pulse: load complete, start execution
- ROM_data  out  16  registered instruction word
- instr_valid  out  1  ROM_data is a live instruction
- instr_pc  out  16  PC of the word on ROM_data
- pc  out  16  fetch pointer (next address read)
- running  out  1  high in RUN/FLUSH
- pc_oor  out  1  sticky: fetch address was >= 2**ADDR_W

Behaviour:
- Reset values:
  - state = IDLE; pc = RESET_PC; instr_pc = 0.
  - ROM_data = 16'h0000; instr_valid = 0; running = 0; pc_oor = 0.
  - Memory contents are not reset.
- States: IDLE, LOAD, RUN, FLUSH.
  - IDLE -> LOAD on prog_we; IDLE -> RUN on prog_done.
  - LOAD -> RUN on prog_done. prog_done with prog_we in the same cycle: the write occurs, then the state moves to RUN.
  - RUN -> FLUSH on a taken redirect; FLUSH -> RUN after exactly 1 cycle.
  - There is no exit from RUN except reset.
- Program load:
  - In IDLE/LOAD, prog_we writes mem[prog_addr[ADDR_W-1:0]] <= prog_data.
  - Writes with prog_addr >= 2**ADDR_W are dropped.
  - prog_we is ignored in RUN/FLUSH.
- Fetch, in RUN with rom_rd=1 and no taken redirect:
  - ROM_data <= mem[pc[ADDR_W-1:0]]; instr_pc <= pc; instr_valid <= 1; pc <= pc+1 (16-bit wrap).
  - Read latency: 1 cycle.
- Stall, rom_rd=0 and no redirect: pc, ROM_data, instr_pc and instr_valid all hold.
- Redirect:
  - Evaluated every RUN cycle against the instruction on ROM_data, and only when instr_valid=1.
  - PC_MUX=01: no redirect.
  - PC_MUX=10 with branch_taken=1: target = instr_pc + 1 + sign_extend(branch_offset).
  - PC_MUX=10 with branch_taken=0: behaves as 01.
  - PC_MUX=11: target = {instr_pc[15:12], jump_addr}.
  - PC_MUX=00: target = jr_target.
  - All arithmetic is 16-bit modulo.
- Taken redirect:
  - pc <= target; instr_valid <= 0; ROM_data holds; state -> FLUSH.
  - Redirect overrides rom_rd=0.
  - FLUSH: no redirect is evaluated (instr_valid=0). A fetch occurs if rom_rd=1, then the state returns to RUN.
  - Branch/jump penalty: exactly 1 bubble.
- pc_oor:
  - Set when a fetch reads with pc >= 2**ADDR_W. The low bits still index memory (aliasing).
  - Cleared only by reset.
- Reset mid-operation: asynchronous return to the reset values above. Memory is retained, so software reload is optional; a prog_done pulse restarts from RESET_PC.
- No fetch and no redirect occur in IDLE/LOAD; instr_valid stays 0 there.

Decomposition:
- Shared package myMIPS_pkg:
  - PC_MUX encodings (PCSEL_JR=00, PCSEL_SEQ=01, PCSEL_BR=10, PCSEL_J=11).
  - Instruction field bit positions (opcode 15:12, rs 11:9, rt 8:6, rd 5:3, imm 5:0, addr 11:0).
  - Fetch state encodings.
- Sub-module imem_ram:
  - Single-port synchronous RAM, 2**ADDR_W x 16.
  - One write port muxed between load and nothing, one registered read.
  - Keeps the FSM/PC logic in imem_fetch.

Test Plan:
- Load 0x1000..0x1003 at addresses 0..3, pulse prog_done, rom_rd=1 -> instr_valid rises 1 cycle later; ROM_data sequence is 0x1000, 0x1001, 0x1002, 0x1003 with instr_pc 0, 1, 2, 3.
- Hold rom_rd=0 for 3 cycles mid-stream at instr_pc=2 -> ROM_data=0x1002 and pc=3 held; the stream resumes with 0x1003.
- Branch with instr_pc=4, PC_MUX=10, branch_taken=1, branch_offset=6'b111110 (-2) -> 1 bubble (instr_valid=0), then instr_pc=3. Same with branch_taken=0 -> no bubble, instr_pc=5.
- j with instr_pc=0x0005, jump_addr=12'h020 -> next valid instr_pc=0x0020. jr with jr_target=0x0007 -> next valid instr_pc=7.
- With ADDR_W=8, jr_target=0x0105 -> ROM_data=mem[5] and pc_oor=1. pc_oor stays high until reset.
- Assert rst low mid-run -> all outputs return to reset values immediately; after a prog_done pulse, fetch restarts at RESET_PC with previously loaded contents intact.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the myMIPS instruction fetch slice: PC_MUX encodings,
// instruction field layout, fetch FSM states and an immediate sign-extend helper.
package imem_fetch_pkg;

    localparam logic [1:0] PCSEL_JR  = 2'b00;
    localparam logic [1:0] PCSEL_SEQ = 2'b01;
    localparam logic [1:0] PCSEL_BR  = 2'b10;
    localparam logic [1:0] PCSEL_J   = 2'b11;

    localparam int XLEN    = 16;
    localparam int IMM_W   = 6;   // instr[5:0]
    localparam int JADDR_W = 12;  // instr[11:0]

    // R-format layout: opcode 15:12, rs 11:9, rt 8:6, rd 5:3
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [2:0] funct;
    } instr_r_t;

    // I-format / J-format share the low field: imm 5:0, addr 11:0
    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] addr;
    } instr_j_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FLUSH = 2'b11
    } fetch_state_e;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Control-unit <-> fetch-unit bus: fetch request, PC redirect controls,
// boot-time program load, and the returned instruction stream.
interface imem_fetch_if;
    import imem_fetch_pkg::*;

    logic                rom_rd;
    logic [1:0]          PC_MUX;
    logic                branch_taken;
    logic [IMM_W-1:0]    branch_offset;
    logic [JADDR_W-1:0]  jump_addr;
    logic [XLEN-1:0]     jr_target;
    logic                prog_we;
    logic [XLEN-1:0]     prog_addr;
    logic [XLEN-1:0]     prog_data;
    logic                prog_done;
    logic [XLEN-1:0]     ROM_data;
    logic                instr_valid;
    logic [XLEN-1:0]     instr_pc;
    logic [XLEN-1:0]     pc;
    logic                running;
    logic                pc_oor;

    modport slave (
        input  rom_rd, PC_MUX, branch_taken, branch_offset, jump_addr, jr_target,
        input  prog_we, prog_addr, prog_data, prog_done,
        output ROM_data, instr_valid, instr_pc, pc, running, pc_oor
    );

    modport master (
        output rom_rd, PC_MUX, branch_taken, branch_offset, jump_addr, jr_target,
        output prog_we, prog_addr, prog_data, prog_done,
        input  ROM_data, instr_valid, instr_pc, pc, running, pc_oor
    );

endinterface

// File: rtl/imem_fetch_ram.sv
// Single-port synchronous instruction RAM with a registered read word.
// The read register only updates on a read strobe, so it holds across stalls.
module imem_fetch_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [0:(1<<ADDR_W)-1];
    logic [15:0] rdata_q;

    // Memory array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 16'h0000;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch responder: program counter, fetch FSM (IDLE/LOAD/RUN/FLUSH),
// PC_MUX redirect with one-bubble squash, and the program-load path into the RAM.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    imem_fetch_if.slave fetch_io
);

    fetch_state_e      state_q, state_d;
    logic [15:0]       pc_q, pc_d, ipc_q, ipc_d, target_s;
    logic              valid_q, valid_d, oor_q, oor_d, running_q, running_d;
    logic              sel_taken_s, redirect_s, fetch_s, loading_s, ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;

    // Redirect decode against the instruction currently on ROM_data
    always_comb begin
        sel_taken_s = 1'b0;
        target_s    = pc_q;
        case (fetch_io.PC_MUX)
            PCSEL_BR: begin
                sel_taken_s = fetch_io.branch_taken;
                target_s    = ipc_q + 16'd1 + sext_imm(fetch_io.branch_offset);
            end
            PCSEL_J: begin
                sel_taken_s = 1'b1;
                target_s    = {ipc_q[15:JADDR_W], fetch_io.jump_addr};
            end
            PCSEL_JR: begin
                sel_taken_s = 1'b1;
                target_s    = fetch_io.jr_target;
            end
            default: begin
                sel_taken_s = 1'b0;
                target_s    = pc_q;
            end
        endcase
        redirect_s = (state_q == ST_RUN) && valid_q && sel_taken_s;
        fetch_s    = fetch_io.rom_rd && !redirect_s &&
                     ((state_q == ST_RUN) || (state_q == ST_FLUSH));
        loading_s  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    end

    // Single RAM port: load address while loading, fetch pointer otherwise
    always_comb begin
        ram_we_s = loading_s && fetch_io.prog_we && ((fetch_io.prog_addr >> ADDR_W) == 16'd0);
        if (loading_s) begin
            ram_addr_s = fetch_io.prog_addr[ADDR_W-1:0];
        end else begin
            ram_addr_s = pc_q[ADDR_W-1:0];
        end
    end

    // Next-state and fetch-pointer logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        oor_d   = oor_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_io.prog_done) begin
                    state_d = ST_RUN;
                end else if (fetch_io.prog_we) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (fetch_io.prog_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (redirect_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect_s) begin
            pc_d    = target_s;
            valid_d = 1'b0;
        end else if (fetch_s) begin
            pc_d    = pc_q + 16'd1;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            oor_d   = oor_q | ((pc_q >> ADDR_W) != 16'd0);
        end else begin
            pc_d = pc_q;
        end
        running_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ipc_q     <= 16'h0000;
            valid_q   <= 1'b0;
            oor_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            oor_q     <= oor_d;
            running_q <= running_d;
        end
    end

    imem_fetch_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we_s),
        .re_i    (fetch_s),
        .addr_i  (ram_addr_s),
        .wdata_i (fetch_io.prog_data),
        .rdata_o (fetch_io.ROM_data)
    );

    assign fetch_io.instr_valid = valid_q;
    assign fetch_io.instr_pc    = ipc_q;
    assign fetch_io.pc          = pc_q;
    assign fetch_io.running     = running_q;
    assign fetch_io.pc_oor      = oor_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed vector table for the fetch/stall/redirect stream,
// a mid-run reset sequence, then random traffic against a behavioural model.
module tb_imem_fetch;
    import imem_fetch_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [15:0] RPC   = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    imem_fetch_if bus_if();

    imem_fetch #(.ADDR_W(8), .RESET_PC(RPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (bus_if)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic [15:0] m_mem [DEPTH];
    bit          m_run, m_flush, m_valid, m_oor;
    logic [15:0] m_pc, m_ipc, m_rom;

    typedef struct {
        logic        rd;
        logic [1:0]  sel;
        logic        tk;
        logic [5:0]  off;
        logic [11:0] ja;
        logic [15:0] jr;
        logic        v;
        logic [15:0] ipc;
        logic [15:0] rom;
        logic [15:0] pc;
        logic        oor;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_flush = 1'b0; m_valid = 1'b0; m_oor = 1'b0;
        m_pc = RPC; m_ipc = 16'h0000; m_rom = 16'h0000;
    endtask

    // One clock of architectural behaviour, using the inputs about to be sampled
    task automatic model_step();
        int t;
        int offv;
        logic [1:0] sel;
        sel = bus_if.PC_MUX;
        if (!m_run) begin
            if (bus_if.prog_we && int'(bus_if.prog_addr) < DEPTH)
                m_mem[int'(bus_if.prog_addr)] = bus_if.prog_data;
            if (bus_if.prog_done) begin
                m_run = 1'b1;
                m_flush = 1'b0;
            end
        end else if (!m_flush && m_valid &&
                     ((sel == PCSEL_BR && bus_if.branch_taken) || sel == PCSEL_J || sel == PCSEL_JR)) begin
            if (sel == PCSEL_BR) begin
                offv = int'(bus_if.branch_offset);
                if (offv >= 32) offv = offv - 64;
                t = int'(m_ipc) + 1 + offv;
            end else if (sel == PCSEL_J) begin
                t = (int'(m_ipc) / 4096) * 4096 + int'(bus_if.jump_addr);
            end else begin
                t = int'(bus_if.jr_target);
            end
            m_pc = t[15:0];
            m_valid = 1'b0;
            m_flush = 1'b1;
        end else begin
            if (bus_if.rom_rd) begin
                if (int'(m_pc) >= DEPTH) m_oor = 1'b1;
                m_rom = m_mem[int'(m_pc) % DEPTH];
                m_ipc = m_pc;
                m_valid = 1'b1;
                m_pc = m_pc + 16'd1;
            end
            m_flush = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 32'(bus_if.instr_valid), 32'(m_valid));
        chk({tag, "_ipc"},   32'(bus_if.instr_pc),    32'(m_ipc));
        chk({tag, "_rom"},   32'(bus_if.ROM_data),    32'(m_rom));
        chk({tag, "_pc"},    32'(bus_if.pc),          32'(m_pc));
        chk({tag, "_run"},   32'(bus_if.running),     32'(m_run));
        chk({tag, "_oor"},   32'(bus_if.pc_oor),      32'(m_oor));
    endtask

    task automatic idle_inputs();
        bus_if.rom_rd = 1'b0; bus_if.PC_MUX = PCSEL_SEQ; bus_if.branch_taken = 1'b0;
        bus_if.branch_offset = 6'd0; bus_if.jump_addr = 12'd0; bus_if.jr_target = 16'd0;
        bus_if.prog_we = 1'b0; bus_if.prog_addr = 16'd0; bus_if.prog_data = 16'd0;
        bus_if.prog_done = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},    32'(bus_if.pc),          32'(RPC));
        chk({tag, "_ipc"},   32'(bus_if.instr_pc),    32'h0);
        chk({tag, "_rom"},   32'(bus_if.ROM_data),    32'h0);
        chk({tag, "_valid"}, 32'(bus_if.instr_valid), 32'h0);
        chk({tag, "_run"},   32'(bus_if.running),     32'h0);
        chk({tag, "_oor"},   32'(bus_if.pc_oor),      32'h0);
    endtask

    initial begin
        //          rd    sel        tk    off     ja       jr         v     ipc       rom       pc        oor
        vecs[0]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0000, 16'h1000, 16'h0001, 1'b0};
        vecs[1]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0001, 16'h1001, 16'h0002, 1'b0};
        vecs[2]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0002, 16'h1002, 16'h0003, 1'b0};
        vecs[3]  = '{1'b0, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0002, 16'h1002, 16'h0003, 1'b0};
        vecs[4]  = '{1'b0, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0002, 16'h1002, 16'h0003, 1'b0};
        vecs[5]  = '{1'b0, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0002, 16'h1002, 16'h0003, 1'b0};
        vecs[6]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0003, 16'h1003, 16'h0004, 1'b0};
        vecs[7]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0004, 16'h1004, 16'h0005, 1'b0};
        vecs[8]  = '{1'b1, PCSEL_BR,  1'b1, 6'h3E, 12'h000, 16'h0000, 1'b0, 16'h0004, 16'h1004, 16'h0003, 1'b0};
        vecs[9]  = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0003, 16'h1003, 16'h0004, 1'b0};
        vecs[10] = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0004, 16'h1004, 16'h0005, 1'b0};
        vecs[11] = '{1'b1, PCSEL_BR,  1'b0, 6'h3E, 12'h000, 16'h0000, 1'b1, 16'h0005, 16'h1005, 16'h0006, 1'b0};
        vecs[12] = '{1'b1, PCSEL_J,   1'b0, 6'h00, 12'h020, 16'h0000, 1'b0, 16'h0005, 16'h1005, 16'h0020, 1'b0};
        vecs[13] = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0020, 16'h1020, 16'h0021, 1'b0};
        vecs[14] = '{1'b1, PCSEL_JR,  1'b0, 6'h00, 12'h000, 16'h0007, 1'b0, 16'h0020, 16'h1020, 16'h0007, 1'b0};
        vecs[15] = '{1'b0, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b0, 16'h0020, 16'h1020, 16'h0007, 1'b0};
        vecs[16] = '{1'b0, PCSEL_JR,  1'b0, 6'h00, 12'h000, 16'h0050, 1'b0, 16'h0020, 16'h1020, 16'h0007, 1'b0};
        vecs[17] = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0007, 16'h1007, 16'h0008, 1'b0};
        vecs[18] = '{1'b0, PCSEL_JR,  1'b0, 6'h00, 12'h000, 16'h0105, 1'b0, 16'h0007, 16'h1007, 16'h0105, 1'b0};
        vecs[19] = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0105, 16'h1005, 16'h0106, 1'b1};
        vecs[20] = '{1'b1, PCSEL_SEQ, 1'b0, 6'h00, 12'h000, 16'h0000, 1'b1, 16'h0106, 16'h1006, 16'h0107, 1'b1};

        idle_inputs();
        model_reset();
        #2 rst = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // program load: mem[i] = 0x1000 + i, then an out-of-range write that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.prog_we = 1'b1;
            bus_if.prog_addr = 16'(i);
            bus_if.prog_data = 16'h1000 + 16'(i);
            tick();
            if (i == 0) chk("load_running", 32'(bus_if.running), 32'h0);
        end
        bus_if.prog_addr = 16'h0100;
        bus_if.prog_data = 16'hDEAD;
        tick();
        bus_if.prog_we = 1'b0;
        bus_if.prog_done = 1'b1;
        tick();
        bus_if.prog_done = 1'b0;
        chk("start_running", 32'(bus_if.running), 32'h1);
        chk("start_valid", 32'(bus_if.instr_valid), 32'h0);
        chk("start_pc", 32'(bus_if.pc), 32'(RPC));

        for (int v = 0; v < 21; v++) begin
            bus_if.rom_rd = vecs[v].rd;
            bus_if.PC_MUX = vecs[v].sel;
            bus_if.branch_taken = vecs[v].tk;
            bus_if.branch_offset = vecs[v].off;
            bus_if.jump_addr = vecs[v].ja;
            bus_if.jr_target = vecs[v].jr;
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(bus_if.instr_valid), 32'(vecs[v].v));
            chk($sformatf("vec%0d_ipc", v),   32'(bus_if.instr_pc),    32'(vecs[v].ipc));
            chk($sformatf("vec%0d_rom", v),   32'(bus_if.ROM_data),    32'(vecs[v].rom));
            chk($sformatf("vec%0d_pc", v),    32'(bus_if.pc),          32'(vecs[v].pc));
            chk($sformatf("vec%0d_oor", v),   32'(bus_if.pc_oor),      32'(vecs[v].oor));
        end
        check_model("after_vec");

        // asynchronous reset mid-run, then restart with memory retained
        #3 rst = 1'b0;
        idle_inputs();
        model_reset();
        #1 check_reset_values("midrst");
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("rst_idle_running", 32'(bus_if.running), 32'h0);
        bus_if.prog_we = 1'b1;
        bus_if.prog_addr = 16'h0000;
        bus_if.prog_data = 16'hA5A5;
        bus_if.prog_done = 1'b1;
        tick();
        idle_inputs();
        chk("restart_running", 32'(bus_if.running), 32'h1);
        bus_if.rom_rd = 1'b1;
        tick();
        chk("restart_rom0", 32'(bus_if.ROM_data), 32'h0000A5A5);
        chk("restart_ipc0", 32'(bus_if.instr_pc), 32'h0);
        tick();
        chk("restart_rom1", 32'(bus_if.ROM_data), 32'h00001001);
        chk("restart_oor", 32'(bus_if.pc_oor), 32'h0);
        check_model("restart");

        // random traffic; load strobes in RUN must be ignored
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 7));
            bus_if.rom_rd = ($urandom_range(0, 3) != 0);
            if (r == 4)      bus_if.PC_MUX = PCSEL_BR;
            else if (r == 5) bus_if.PC_MUX = PCSEL_J;
            else if (r == 6) bus_if.PC_MUX = PCSEL_JR;
            else             bus_if.PC_MUX = PCSEL_SEQ;
            bus_if.branch_taken = 1'($urandom_range(0, 1));
            bus_if.branch_offset = 6'($urandom);
            bus_if.jump_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255));
            bus_if.jr_target = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            bus_if.prog_we = 1'($urandom_range(0, 1));
            bus_if.prog_addr = 16'($urandom_range(0, 255));
            bus_if.prog_data = 16'($urandom);
            bus_if.prog_done = ($urandom_range(0, 15) == 0);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
